// File: rtl/csa_accum_pkg.sv
// Shared types and elaboration helpers for the folded carry-save accumulator.
package csa_accum_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    ADD    = 2'd2,
    RESULT = 2'd3
  } state_t;

  // Width of a counter that must hold every value from 0 to max_beats inclusive.
  function automatic int cnt_width(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/compressor_tree_3_to_2.sv
// Reduces NUM_ELEMENTS operands to a redundant carry/sum pair with 3:2 counters.
// All arithmetic is mod 2^BIT_LEN: the carry shifted out of the MSB is dropped.
module compressor_tree_3_to_2 #(
  parameter int NUM_ELEMENTS = 6,
  parameter int BIT_LEN      = 16
) (
  input  logic [BIT_LEN-1:0] terms [NUM_ELEMENTS],
  output logic [BIT_LEN-1:0] c,
  output logic [BIT_LEN-1:0] s
);

  logic [BIT_LEN-1:0] s_chain [1:NUM_ELEMENTS-1];
  logic [BIT_LEN-1:0] c_chain [1:NUM_ELEMENTS-1];

  assign s_chain[1] = terms[0];
  assign c_chain[1] = terms[1];

  for (genvar i = 2; i < NUM_ELEMENTS; i++) begin : g_csa
    logic [BIT_LEN-1:0] maj;
    assign maj = (s_chain[i-1] & c_chain[i-1]) |
                 (s_chain[i-1] & terms[i])     |
                 (c_chain[i-1] & terms[i]);
    assign s_chain[i] = s_chain[i-1] ^ c_chain[i-1] ^ terms[i];
    assign c_chain[i] = {maj[BIT_LEN-2:0], 1'b0};
  end

  assign s = s_chain[NUM_ELEMENTS-1];
  assign c = c_chain[NUM_ELEMENTS-1];

endmodule

// File: rtl/csa_accum_sequencer.sv
// Folded multi-operand accumulator: compresses each beat into a carry/sum pair,
// then resolves the pair with one carry-propagate add and offers it on valid/ready.
module csa_accum_sequencer
  import csa_accum_pkg::*;
#(
  parameter int TERMS_PER_BEAT = 4,
  parameter int BIT_LEN        = 16,
  parameter int MAX_BEATS      = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [BIT_LEN-1:0]                 in_terms [TERMS_PER_BEAT],
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [BIT_LEN-1:0]                 out_sum,
  output logic [cnt_width(MAX_BEATS)-1:0]    out_beats,
  output logic                               out_overflow
);

  localparam int                CNT_W        = cnt_width(MAX_BEATS);
  localparam int                NUM_ELEMENTS = TERMS_PER_BEAT + 2;
  localparam logic [CNT_W-1:0]  BEAT_LIMIT   = CNT_W'(MAX_BEATS);

  state_t             state, state_next;
  logic [BIT_LEN-1:0] acc_c, acc_s;
  logic [BIT_LEN-1:0] tree_c, tree_s;
  logic [BIT_LEN-1:0] tree_terms [NUM_ELEMENTS];
  logic [CNT_W-1:0]   beat_cnt;
  logic               ovf;
  logic               accept, clear_acc, load_result;

  // Fresh operands followed by the fed-back redundant accumulator pair.
  always_comb begin
    for (int i = 0; i < TERMS_PER_BEAT; i++) tree_terms[i] = in_terms[i];
    tree_terms[TERMS_PER_BEAT]     = acc_c;
    tree_terms[TERMS_PER_BEAT + 1] = acc_s;
  end

  compressor_tree_3_to_2 #(
    .NUM_ELEMENTS (NUM_ELEMENTS),
    .BIT_LEN      (BIT_LEN)
  ) u_tree (
    .terms (tree_terms),
    .c     (tree_c),
    .s     (tree_s)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    accept      = 1'b0;
    clear_acc   = 1'b0;
    load_result = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        in_ready = !flush;
        accept   = in_valid && !flush;
        if (flush) begin
          state_next = IDLE;
          clear_acc  = 1'b1;
        end else if (in_valid) begin
          state_next = in_last ? ADD : ACCUM;
        end
      end
      ADD: begin
        if (flush) begin
          state_next = IDLE;
          clear_acc  = 1'b1;
        end else begin
          state_next  = RESULT;
          load_result = 1'b1;
        end
      end
      RESULT: begin
        // A pending result survives flush; only the consumer or rst retires it.
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
          clear_acc  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: registers take non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_c        <= '0;
      acc_s        <= '0;
      beat_cnt     <= '0;
      ovf          <= 1'b0;
      out_sum      <= '0;
      out_beats    <= '0;
      out_overflow <= 1'b0;
    end else begin
      if (clear_acc) begin
        acc_c    <= '0;
        acc_s    <= '0;
        beat_cnt <= '0;
        ovf      <= 1'b0;
      end else if (accept) begin
        acc_c <= tree_c;
        acc_s <= tree_s;
        if (beat_cnt == BEAT_LIMIT) ovf <= 1'b1;
        else                        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (load_result) begin
        out_sum      <= acc_c + acc_s;
        out_beats    <= beat_cnt;
        out_overflow <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_csa_accum_sequencer.sv
// Randomized and directed checks of csa_accum_sequencer against a plain-arithmetic packet model.
module tb_csa_accum_sequencer;

  localparam int T  = 4;
  localparam int W  = 16;
  localparam int MB = 4;
  localparam int CW = $clog2(MB + 1);

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_last, out_ready;
  logic [W-1:0]  in_terms [T];
  logic          in_ready, out_valid, out_overflow;
  logic [W-1:0]  out_sum;
  logic [CW-1:0] out_beats;

  int vectors = 0;
  int errors  = 0;

  // Reference model: running integer sum and beat count of the current packet.
  longint unsigned m_sum;
  int              m_beats;

  csa_accum_sequencer #(
    .TERMS_PER_BEAT (T),
    .BIT_LEN        (W),
    .MAX_BEATS      (MB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_terms     (in_terms),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_beats    (out_beats),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] exp_sum();
    return m_sum[W-1:0];
  endfunction

  function automatic logic [CW-1:0] exp_beats();
    return (m_beats > MB) ? CW'(MB) : CW'(m_beats);
  endfunction

  function automatic logic exp_ovf();
    return m_beats > MB;
  endfunction

  task automatic model_clear();
    m_sum   = 0;
    m_beats = 0;
  endtask

  // Offers one beat until accepted (bounded); called just after a rising edge.
  task automatic send_beat(input logic [W-1:0] a, b, c, d, input logic last);
    bit acc;
    acc = 1'b0;
    in_terms[0] = a; in_terms[1] = b; in_terms[2] = c; in_terms[3] = d;
    in_last  = last;
    in_valid = 1'b1;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    vectors++;
    if (!acc) begin
      errors++;
      $display("FAIL beat_accept: accepted=%0b want=1", acc);
    end else begin
      m_sum   += longint'(a) + longint'(b) + longint'(c) + longint'(d);
      m_beats++;
    end
  endtask

  // Waits (bounded) for a completed output handshake and returns what was presented.
  task automatic wait_result(input bit rand_ready, output bit got, output logic [W-1:0] s,
                             output logic [CW-1:0] bts, output logic o);
    got = 1'b0; s = '0; bts = '0; o = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        got = 1'b1; s = out_sum; bts = out_beats; o = out_overflow;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
  endtask

  // Waits (bounded) for out_valid; returns at the falling edge where it was seen.
  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < T; i++) in_terms[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got=%0b want=1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got=%0b want=0", out_valid); end
    vectors++; if (out_sum !== '0) begin errors++; $display("FAIL reset_out_sum: got=%0h want=0", out_sum); end
    vectors++; if (out_beats !== '0) begin errors++; $display("FAIL reset_out_beats: got=%0d want=0", out_beats); end
    vectors++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL reset_out_overflow: got=%0b want=0", out_overflow); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_beat();
    model_clear();
    out_ready = 1'b1;
    send_beat(16'd1, 16'd2, 16'd3, 16'd4, 1'b1);
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_add_valid: got=%0b want=0", out_valid); end
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_add_ready: got=%0b want=0", in_ready); end
    @(negedge clk);
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: got=%0b want=1", out_valid); end
    vectors++; if (out_sum !== exp_sum()) begin errors++; $display("FAIL single_sum: got=%0h want=%0h", out_sum, exp_sum()); end
    vectors++; if (out_beats !== exp_beats()) begin errors++; $display("FAIL single_beats: got=%0d want=%0d", out_beats, exp_beats()); end
    vectors++; if (out_overflow !== exp_ovf()) begin errors++; $display("FAIL single_ovf: got=%0b want=%0b", out_overflow, exp_ovf()); end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_retire: got=%0b want=0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    bit got; logic [W-1:0] s; logic [CW-1:0] b; logic o;
    model_clear();
    for (int i = 0; i < 3; i++) send_beat('1, '1, '1, '1, i == 2);
    wait_result(1'b0, got, s, b, o);
    vectors++; if (got !== 1'b1) begin errors++; $display("FAIL wrap_done: got=%0b want=1", got); end
    vectors++; if (s !== exp_sum()) begin errors++; $display("FAIL wrap_sum: got=%0h want=%0h", s, exp_sum()); end
    vectors++; if (b !== exp_beats()) begin errors++; $display("FAIL wrap_beats: got=%0d want=%0d", b, exp_beats()); end
  endtask

  task automatic test_backpressure();
    bit got; logic [W-1:0] s; logic [CW-1:0] b; logic o;
    model_clear();
    out_ready = 1'b0;
    send_beat(16'd9, 16'd8, 16'd7, 16'd6, 1'b1);
    wait_valid(got);
    vectors++; if (got !== 1'b1) begin errors++; $display("FAIL bp_valid: got=%0b want=1", got); end
    for (int k = 0; k < 5; k++) begin
      vectors++; if (out_sum !== exp_sum()) begin errors++; $display("FAIL bp_sum_stable: got=%0h want=%0h", out_sum, exp_sum()); end
      vectors++; if (out_beats !== exp_beats()) begin errors++; $display("FAIL bp_beats_stable: got=%0d want=%0d", out_beats, exp_beats()); end
      vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got=%0b want=0", in_ready); end
      vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held: got=%0b want=1", out_valid); end
      @(posedge clk); #1;
      flush = (k == 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    model_clear();
    send_beat(16'd5, 16'd0, 16'd0, 16'd0, 1'b1);
    wait_result(1'b0, got, s, b, o);
    vectors++; if (got !== 1'b1) begin errors++; $display("FAIL bp_next_done: got=%0b want=1", got); end
    vectors++; if (s !== exp_sum()) begin errors++; $display("FAIL bp_next_sum: got=%0h want=%0h", s, exp_sum()); end
  endtask

  task automatic test_flush();
    bit got; logic [W-1:0] s; logic [CW-1:0] b; logic o;
    model_clear();
    send_beat(16'd1, 16'd1, 16'd1, 16'd1, 1'b0);
    send_beat(16'd1, 16'd1, 16'd1, 16'd1, 1'b0);
    in_terms[0] = 16'd1; in_terms[1] = 16'd1; in_terms[2] = 16'd1; in_terms[3] = 16'd1;
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got=%0b want=0", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    model_clear();
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got=%0b want=0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle_ready: got=%0b want=1", in_ready); end
    @(posedge clk); #1;
    send_beat(16'd1, 16'd1, 16'd1, 16'd1, 1'b1);
    wait_result(1'b0, got, s, b, o);
    vectors++; if (got !== 1'b1) begin errors++; $display("FAIL flush_done: got=%0b want=1", got); end
    vectors++; if (s !== exp_sum()) begin errors++; $display("FAIL flush_sum: got=%0h want=%0h", s, exp_sum()); end
    vectors++; if (b !== exp_beats()) begin errors++; $display("FAIL flush_beats: got=%0d want=%0d", b, exp_beats()); end
  endtask

  task automatic test_overflow();
    bit got; logic [W-1:0] s; logic [CW-1:0] b; logic o;
    model_clear();
    for (int i = 0; i < 6; i++) send_beat(16'd1, 16'd0, 16'd0, 16'd0, i == 5);
    wait_result(1'b0, got, s, b, o);
    vectors++; if (got !== 1'b1) begin errors++; $display("FAIL ovf_done: got=%0b want=1", got); end
    vectors++; if (s !== exp_sum()) begin errors++; $display("FAIL ovf_sum: got=%0h want=%0h", s, exp_sum()); end
    vectors++; if (b !== exp_beats()) begin errors++; $display("FAIL ovf_beats: got=%0d want=%0d", b, exp_beats()); end
    vectors++; if (o !== exp_ovf()) begin errors++; $display("FAIL ovf_flag: got=%0b want=%0b", o, exp_ovf()); end
    model_clear();
    send_beat(16'd2, 16'd3, 16'd0, 16'd0, 1'b1);
    wait_result(1'b0, got, s, b, o);
    vectors++; if (o !== exp_ovf()) begin errors++; $display("FAIL ovf_next_clear: got=%0b want=%0b", o, exp_ovf()); end
    vectors++; if (b !== exp_beats()) begin errors++; $display("FAIL ovf_next_beats: got=%0d want=%0d", b, exp_beats()); end
  endtask

  task automatic test_rst_in_result();
    bit got; logic [W-1:0] s; logic [CW-1:0] b; logic o;
    model_clear();
    out_ready = 1'b0;
    send_beat(16'd3, 16'd3, 16'd3, 16'd3, 1'b1);
    wait_valid(got);
    vectors++; if (got !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got=%0b want=1", got); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_clear();
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got=%0b want=0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got=%0b want=1", in_ready); end
    vectors++; if (out_sum !== '0) begin errors++; $display("FAIL rst_out_sum: got=%0h want=0", out_sum); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_beat(16'd7, 16'd0, 16'd0, 16'd0, 1'b1);
    wait_result(1'b0, got, s, b, o);
    vectors++; if (got !== 1'b1) begin errors++; $display("FAIL rst_next_done: got=%0b want=1", got); end
    vectors++; if (s !== exp_sum()) begin errors++; $display("FAIL rst_next_sum: got=%0h want=%0h", s, exp_sum()); end
  endtask

  task automatic test_random();
    bit got; logic [W-1:0] s; logic [CW-1:0] b; logic o;
    int nb;
    for (int p = 0; p < 30; p++) begin
      model_clear();
      nb = $urandom_range(1, 6);
      for (int j = 0; j < nb; j++) begin
        if (j > 0 && $urandom_range(0, 9) == 0) begin
          flush = 1'b1;
          @(posedge clk); #1;
          flush = 1'b0;
          model_clear();
        end
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        send_beat(W'($urandom), W'($urandom), W'($urandom), W'($urandom), j == nb - 1);
      end
      wait_result(1'b1, got, s, b, o);
      vectors++; if (got !== 1'b1) begin errors++; $display("FAIL rand_done[%0d]: got=%0b want=1", p, got); end
      vectors++; if (s !== exp_sum()) begin errors++; $display("FAIL rand_sum[%0d]: got=%0h want=%0h", p, s, exp_sum()); end
      vectors++; if (b !== exp_beats()) begin errors++; $display("FAIL rand_beats[%0d]: got=%0d want=%0d", p, b, exp_beats()); end
      vectors++; if (o !== exp_ovf()) begin errors++; $display("FAIL rand_ovf[%0d]: got=%0b want=%0b", p, o, exp_ovf()); end
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_wrap();
    test_backpressure();
    test_flush();
    test_overflow();
    test_rst_in_result();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
